// File: rtl/bf_program_loader_if.sv
// rtl/bf_program_loader_if.sv - byte stream in and program memory write port of the BF program loader
// slave is the loader side; master is the byte source / memory side.
interface bf_program_loader_if #(
   parameter int ADDR_W = 8
);
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              prog_we;
   logic [ADDR_W-1:0] prog_addr;
   logic [3:0]        prog_wdata;

   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready,
      output prog_we,
      output prog_addr,
      output prog_wdata
   );

   modport master (
      output in_data,
      output in_valid,
      input  in_ready,
      input  prog_we,
      input  prog_addr,
      input  prog_wdata
   );
endinterface

// File: rtl/bf_program_loader.sv
// rtl/bf_program_loader.sv - encodes an ASCII BF program into opcodes and loads program memory
// Optional BF_LOADER_STRICT_EN: reject any byte that is not a command, TERM_CHAR or whitespace.
module bf_program_loader #(
   parameter int          ADDR_W    = 8,
   parameter int          DEPTH_W   = 8,
   parameter logic [7:0]  TERM_CHAR = 8'h21
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   bf_program_loader_if.slave bus,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [2:0]        err_code,
   output logic [ADDR_W-1:0] prog_len
);

   localparam logic [3:0] OP_STOP = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RECV,
      S_WRITE,
      S_FINISH,
      S_DONE,
      S_ERRW,
      S_ERR
   } state_t;

   state_t              state_q, state_n;
   logic [ADDR_W-1:0]   addr_q, addr_n;
   logic [DEPTH_W-1:0]  depth_q, depth_n;
   logic [ADDR_W-1:0]   len_q, len_n;
   logic [2:0]          cause_q, cause_n;
   logic [2:0]          err_code_q, err_code_n;
   logic                in_ready_q;
   logic                we_q, we_n;
   logic [ADDR_W-1:0]   paddr_q, paddr_n;
   logic [3:0]          wdata_q, wdata_n;
   logic                busy_q, done_q, error_q;
   logic                accept;
   logic                fail;
   logic [2:0]          fail_code;
   logic [7:0]          c;

   function automatic logic is_cmd(input logic [7:0] ch);
      case (ch)
         8'h3C, 8'h3E, 8'h2B, 8'h2D, 8'h5B, 8'h5D, 8'h2E, 8'h2C: is_cmd = 1'b1;
         default:                                                 is_cmd = 1'b0;
      endcase
   endfunction

   function automatic logic [3:0] opcode(input logic [7:0] ch);
      case (ch)
         8'h3C:   opcode = 4'd0;
         8'h3E:   opcode = 4'd1;
         8'h2B:   opcode = 4'd2;
         8'h2D:   opcode = 4'd3;
         8'h5B:   opcode = 4'd4;
         8'h5D:   opcode = 4'd5;
         8'h2E:   opcode = 4'd6;
         default: opcode = 4'd7;
      endcase
   endfunction

`ifdef BF_LOADER_STRICT_EN
   function automatic logic is_ws(input logic [7:0] ch);
      is_ws = (ch == 8'h20) || (ch == 8'h09) || (ch == 8'h0A) || (ch == 8'h0D);
   endfunction
`endif

   assign c      = bus.in_data;
   assign accept = bus.in_valid && in_ready_q;

   always_comb begin
      state_n    = state_q;
      addr_n     = addr_q;
      depth_n    = depth_q;
      len_n      = len_q;
      cause_n    = cause_q;
      err_code_n = err_code_q;
      we_n       = 1'b0;
      paddr_n    = paddr_q;
      wdata_n    = wdata_q;
      fail       = 1'b0;
      fail_code  = 3'd0;

      case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_n    = S_RECV;
               addr_n     = '0;
               depth_n    = '0;
               len_n      = '0;
               cause_n    = 3'd0;
               err_code_n = 3'd0;
            end
         end
         S_RECV: begin
            if (accept) begin
               if (c == TERM_CHAR) begin
                  // Unbalanced brackets are reported from FINISH; only a clean program gets its stop code here
                  state_n = S_FINISH;
                  if (depth_q != '0) begin
                     cause_n = 3'd2;
                  end else begin
                     we_n    = 1'b1;
                     paddr_n = addr_q;
                     wdata_n = OP_STOP;
                  end
               end else if (is_cmd(c)) begin
                  if (addr_q == '1) begin
                     fail      = 1'b1;
                     fail_code = 3'd3;
                  end else if (c == 8'h5D && depth_q == '0) begin
                     fail      = 1'b1;
                     fail_code = 3'd1;
                  end else if (c == 8'h5B && depth_q == '1) begin
                     fail      = 1'b1;
                     fail_code = 3'd5;
                  end else begin
                     state_n = S_WRITE;
                     we_n    = 1'b1;
                     paddr_n = addr_q;
                     wdata_n = opcode(c);
                     if (c == 8'h5B) depth_n = depth_q + 1'b1;
                     if (c == 8'h5D) depth_n = depth_q - 1'b1;
                  end
               end
`ifdef BF_LOADER_STRICT_EN
               else if (!is_ws(c)) begin
                  fail      = 1'b1;
                  fail_code = 3'd4;
               end
`endif
            end
         end
         S_WRITE: begin
            addr_n  = addr_q + 1'b1;
            len_n   = len_q + 1'b1;
            state_n = S_RECV;
         end
         S_FINISH: begin
            if (cause_q != 3'd0) begin
               state_n = S_ERRW;
               we_n    = 1'b1;
               paddr_n = '0;
               wdata_n = OP_STOP;
            end else begin
               state_n = S_DONE;
            end
         end
         S_ERRW: begin
            state_n    = S_ERR;
            err_code_n = cause_q;
         end
         default: state_n = S_IDLE;
      endcase

      // A stop code at address 0 makes the machine halt at once on a rejected program
      if (fail) begin
         state_n = S_ERRW;
         cause_n = fail_code;
         we_n    = 1'b1;
         paddr_n = '0;
         wdata_n = OP_STOP;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         depth_q    <= '0;
         len_q      <= '0;
         cause_q    <= 3'd0;
         err_code_q <= 3'd0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         paddr_q    <= '0;
         wdata_q    <= 4'd0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q    <= state_n;
         addr_q     <= addr_n;
         depth_q    <= depth_n;
         len_q      <= len_n;
         cause_q    <= cause_n;
         err_code_q <= err_code_n;
         in_ready_q <= (state_n == S_RECV);
         we_q       <= we_n;
         paddr_q    <= paddr_n;
         wdata_q    <= wdata_n;
         busy_q     <= (state_n == S_RECV) || (state_n == S_WRITE) ||
                       (state_n == S_FINISH) || (state_n == S_ERRW);
         done_q     <= (state_n == S_DONE);
         error_q    <= (state_n == S_ERR);
      end
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.prog_we    = we_q;
   assign bus.prog_addr  = paddr_q;
   assign bus.prog_wdata = wdata_q;
   assign busy           = busy_q;
   assign done           = done_q;
   assign error          = error_q;
   assign err_code       = err_code_q;
   assign prog_len       = len_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// tb/tb_bf_program_loader.sv - directed bench for bf_program_loader (8-bit and 3-bit address builds)
module tb_bf_program_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       start8, start3;
   logic [7:0] in_data;
   logic       in_valid;
   bit         use3;

   bf_program_loader_if #(.ADDR_W(8)) bus8 ();
   bf_program_loader_if #(.ADDR_W(3)) bus3 ();

   logic       busy8, done8, error8;
   logic [2:0] code8;
   logic [7:0] len8;
   logic       busy3, done3, error3;
   logic [2:0] code3;
   logic [2:0] len3;

   assign bus8.in_data  = in_data;
   assign bus3.in_data  = in_data;
   assign bus8.in_valid = in_valid & ~use3;
   assign bus3.in_valid = in_valid & use3;

   bf_program_loader #(.ADDR_W(8), .DEPTH_W(8), .TERM_CHAR(8'h21)) u_dut8 (
      .clk(clk), .reset(reset), .start(start8), .bus(bus8),
      .busy(busy8), .done(done8), .error(error8), .err_code(code8), .prog_len(len8)
   );

   bf_program_loader #(.ADDR_W(3), .DEPTH_W(2), .TERM_CHAR(8'h21)) u_dut3 (
      .clk(clk), .reset(reset), .start(start3), .bus(bus3),
      .busy(busy3), .done(done3), .error(error3), .err_code(code3), .prog_len(len3)
   );

   logic       sel_ready, sel_done, sel_error;
   logic [2:0] sel_code;
   logic [7:0] sel_len;
   assign sel_ready = use3 ? bus3.in_ready : bus8.in_ready;
   assign sel_done  = use3 ? done3 : done8;
   assign sel_error = use3 ? error3 : error8;
   assign sel_code  = use3 ? code3 : code8;
   assign sel_len   = use3 ? {5'b0, len3} : len8;

   int n_checks = 0;
   int n_fail   = 0;
   int overlap  = 0;
   logic [11:0] wq8[$];
   logic [11:0] wq3[$];
   logic [11:0] exp_q[$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus8.prog_we) wq8.push_back({bus8.prog_addr, bus8.prog_wdata});
      if (bus3.prog_we) wq3.push_back({5'b0, bus3.prog_addr, bus3.prog_wdata});
      if ((bus8.prog_we && bus8.in_ready) || (bus3.prog_we && bus3.in_ready)) overlap++;
   end

   task automatic ew(input int a, input logic [3:0] d);
      logic [31:0] av;
      av = a;
      exp_q.push_back({av[7:0], d});
   endtask

   task automatic pulse_start();
      @(posedge clk); #1;
      if (use3) start3 = 1'b1; else start8 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      start8 = 1'b0;
   endtask

   task automatic send_str(input string s);
      bit ok;
      for (int i = 0; i < s.len(); i++) begin
         if (sel_done || sel_error) break;
         in_data  = s[i];
         in_valid = 1'b1;
         ok = 1'b0;
         for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (sel_done || sel_error) break;
            if (sel_ready) begin
               @(posedge clk); #1;
               ok = 1'b1;
               break;
            end
         end
         in_valid = 1'b0;
         if (!ok && !(sel_done || sel_error)) check("accept_timeout", 32'd0, 32'd1);
      end
   endtask

   task automatic run(input bit u3, input string s);
      use3 = u3;
      if (u3) wq3.delete(); else wq8.delete();
      pulse_start();
      send_str(s);
      for (int k = 0; k < 40; k++) begin
         if (sel_done || sel_error) break;
         @(negedge clk);
      end
      check({s, "_finished"}, 32'(sel_done | sel_error), 32'd1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_writes(input string tag);
      logic [11:0] q[$];
      if (use3) q = wq3; else q = wq8;
      check({tag, "_nwrites"}, q.size(), exp_q.size());
      for (int i = 0; i < q.size() && i < exp_q.size(); i++)
         check($sformatf("%s_w%0d", tag, i), 32'(q[i]), 32'(exp_q[i]));
   endtask

   initial begin
      reset    = 1'b1;
      start8   = 1'b0;
      start3   = 1'b0;
      in_data  = 8'h00;
      in_valid = 1'b0;
      use3     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset8", {busy8, bus8.in_ready, bus8.prog_we, done8, error8, code8, len8}, 32'd0);
      check("reset3", {busy3, bus3.in_ready, bus3.prog_we, done3, error3, code3, len3}, 32'd0);
      reset = 1'b0;

      run(1'b0, "+[->+<]!");
      exp_q.delete();
      ew(0, 2); ew(1, 4); ew(2, 3); ew(3, 1); ew(4, 2); ew(5, 0); ew(6, 5); ew(7, 15);
      check_writes("t1");
      check("t1_done", 32'(sel_done), 32'd1);
      check("t1_error", 32'(sel_error), 32'd0);
      check("t1_len", 32'(sel_len), 32'd7);

      run(1'b0, "a+ b!");
      exp_q.delete();
`ifdef BF_LOADER_STRICT_EN
      ew(0, 15);
      check_writes("t2");
      check("t2_error", 32'(sel_error), 32'd1);
      check("t2_code", 32'(sel_code), 32'd4);
`else
      ew(0, 2); ew(1, 15);
      check_writes("t2");
      check("t2_done", 32'(sel_done), 32'd1);
      check("t2_len", 32'(sel_len), 32'd1);
`endif

      run(1'b0, "]!");
      exp_q.delete();
      ew(0, 15);
      check_writes("t3");
      check("t3_error", 32'(sel_error), 32'd1);
      check("t3_code", 32'(sel_code), 32'd1);
      check("t3_done", 32'(sel_done), 32'd0);

      run(1'b0, "[[+]!");
      exp_q.delete();
      ew(0, 4); ew(1, 4); ew(2, 2); ew(3, 5); ew(0, 15);
      check_writes("t4");
      check("t4_error", 32'(sel_error), 32'd1);
      check("t4_code", 32'(sel_code), 32'd2);

      run(1'b1, "++++++++");
      exp_q.delete();
      for (int i = 0; i < 7; i++) ew(i, 2);
      ew(0, 15);
      check_writes("t5");
      check("t5_error", 32'(sel_error), 32'd1);
      check("t5_code", 32'(sel_code), 32'd3);

      run(1'b1, "+++++++!");
      exp_q.delete();
      for (int i = 0; i < 7; i++) ew(i, 2);
      ew(7, 15);
      check_writes("t6");
      check("t6_done", 32'(sel_done), 32'd1);
      check("t6_len", 32'(sel_len), 32'd7);

      run(1'b1, "[[[[");
      exp_q.delete();
      ew(0, 4); ew(1, 4); ew(2, 4); ew(0, 15);
      check_writes("t7");
      check("t7_error", 32'(sel_error), 32'd1);
      check("t7_code", 32'(sel_code), 32'd5);

      use3 = 1'b0;
      pulse_start();
      in_data  = 8'h2B;
      in_valid = 1'b1;
      repeat (3) @(posedge clk);
      #3;
      check("t8_busy_before", 32'(busy8), 32'd1);
      reset = 1'b1;
      #1;
      check("t8_async_rst", {busy8, bus8.in_ready, bus8.prog_we, done8, error8}, 32'd0);
      in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      run(1'b0, "-!");
      exp_q.delete();
      ew(0, 3); ew(1, 15);
      check_writes("t8");
      check("t8_done", 32'(sel_done), 32'd1);

      check("we_ready_overlap", overlap, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1);
   end

endmodule
